// File: rtl/serial_frame_if.sv
// Bundle of serial line and demux-control signals shared by the frame sequencer and its environment.
// The master modport belongs to the sequencer and the slave modport to the line driver and demux side.
interface serial_frame_if;
  logic       serin;
  logic [3:0] PB;
  logic [1:0] LB;
  logic       ld;
  logic       busy;
  logic [1:0] port_id;
  logic       done;
  logic       frame_err;

  modport master (
    input  serin,
    output PB, LB, ld, busy, port_id, done, frame_err
  );

  modport slave (
    output serin,
    input  PB, LB, ld, busy, port_id, done, frame_err
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Frame sequencer for the 4-port serial demultiplexer.
// A frame is: start bit, 2-bit port address (MSB first), 4 data bits, stop bit.
module serial_frame_ctrl #(
  parameter logic START_LVL  = 1'b0,
  parameter bit   CHECK_STOP = 1'b1
) (
  input  logic    clk,
  input  logic    rst,
  serial_frame_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADR1, ADR0, DATA, STOP} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic [1:0] port_q;
  logic       done_q;
  logic       err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.serin == START_LVL) state_nxt = ADR1;
      ADR1:    state_nxt = ADR0;
      ADR0:    state_nxt = DATA;
      DATA:    if (cnt == 2'd3) state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Demux controls are decoded from state and registers only, never from serin.
  always_comb begin
    bus.PB   = 4'b0000;
    bus.LB   = 2'd0;
    bus.ld   = 1'b0;
    bus.busy = (state != IDLE);
    if (state == DATA) begin
      bus.PB = 4'b0001 << port_q;
      bus.LB = cnt;
      bus.ld = 1'b1;
    end
  end

  // done/frame_err land in the cycle after STOP, which is already IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 2'd0;
      port_q <= 2'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ADR1: port_q[1] <= bus.serin;
        ADR0: begin
          port_q[0] <= bus.serin;
          cnt       <= 2'd0;
        end
        DATA: cnt <= cnt + 2'd1;
        STOP: begin
          done_q <= 1'b1;
          err_q  <= CHECK_STOP && (bus.serin != ~START_LVL);
        end
        default: ;
      endcase
    end
  end

  assign bus.port_id   = port_q;
  assign bus.done      = done_q;
  assign bus.frame_err = err_q;

endmodule
